// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder, the only arithmetic element used by serial_add_ctrl.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder (LSB first) with valid/ready handshakes on both sides.
// Defining SERIAL_ADD_SUB_EN adds a 'sub' input that selects a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_cout;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
          // Two's-complement subtract: invert b and force carry-in high.
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end else begin
            b_sh_d  = b;
            carry_d = cin;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Counter parks on the last index rather than wrapping.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed table, corner
// sequences and random operands against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    return r;
  endfunction

  // Accepts one operand set and returns with the DUT in the first RUN cycle.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency, result, and the handshake.
  task automatic finish_op(input string name, input logic [W:0] exp, input int ready_delay);
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd9);
    check({name, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({name, "_cout"}, 64'(cout), 64'(exp[W]));
    for (int i = 0; i < ready_delay; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hold_sum;
    logic         rc, rs, hold_cout;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    tick();

    // out_ready has no effect while idle
    out_ready = 1'b1;
    tick(); tick();
    check("idle_oready_in_ready", 64'(in_ready), 64'd1);
    check("idle_oready_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      check($sformatf("vec%0d_run_in_ready", i), 64'(in_ready), 64'd0);
      finish_op($sformatf("vec%0d", i), {vecs[i].exp_cout, vecs[i].exp_sum}, 0);
    end

    // Hold DONE with out_ready low for 5 cycles
    accept(8'h3C, 8'h4D, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("hold_valid_rise", 64'(out_valid), 64'd1);
    hold_sum = sum;
    hold_cout = cout;
    check("hold_sum_val", 64'(hold_sum), 64'h89);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_sum", i), 64'(sum), 64'(hold_sum));
      check($sformatf("hold%0d_cout", i), 64'(cout), 64'(hold_cout));
      check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_in_ready", 64'(in_ready), 64'd1);
    check("hold_release_out_valid", 64'(out_valid), 64'd0);

    // in_valid pulse with new operands during RUN must be ignored
    accept(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int lat;
      lat = 3;
      while (!out_valid && lat < 50) begin
        tick();
        lat++;
      end
      check("ignore_latency", 64'(lat), 64'd9);
      check("ignore_sum", 64'(sum), 64'h33);
      check("ignore_cout", 64'(cout), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Reset during the 4th RUN cycle discards the operation
    accept(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    accept(8'h12, 8'h34, 1'b0, 1'b0);
    finish_op("post_rst", {1'b0, 8'h46}, 0);

`ifdef SERIAL_ADD_SUB_EN
    accept(8'h05, 8'h07, 1'b1, 1'b1);
    finish_op("sub_neg", {1'b0, 8'hFE}, 0);
    accept(8'h07, 8'h05, 1'b0, 1'b1);
    finish_op("sub_pos", {1'b1, 8'h02}, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      accept(ra, rb, rc, rs);
      finish_op($sformatf("rand%0d", i), model(ra, rb, rc, rs), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
